decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipelined RV32 instruction decoder that replaces the single-cycle combinational control decode.
- Accepts fetched instruction words with PC over a valid/ready handshake.
- Decodes R, I (ALU), load, store and LUI formats.
- Buffers decoded bundles in a 2-entry output FIFO that absorbs one cycle of downstream stall.
- Sits between fetch and register-read/execute; supports pipeline flush.

Parameters:
XLEN, 32, width of immediate and PC outputs (32 or 64); immediates sign-extended to XLEN
DEPTH, 2, output buffer entries (power of two, >=2)
ILLEGAL_TRAP, 1, 1: illegal encodings emitted with illegal=1; 0: illegal encodings silently dropped

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all buffered and incoming instructions this cycle
in_valid  in  1  fetch presents instruction
in_ready  out  1  decoder can accept this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  head bundle valid
out_ready  in  1  downstream consumes head
out_pc  out  XLEN  PC of head
rs1_num  out  5  source register 1
rs2_num  out  5  source register 2
rd_num  out  5  destination register
imm  out  XLEN  sign-extended immediate
alu_control  out  4  ALU operation
is_unsigned  out  1  unsigned compare
use_imm  out  1  ALU operand B is imm
reg_write  out  1  rd written (forced 0 when rd=0)
mem_read  out  1  load
mem_write  out  1  store
illegal  out  1  unsupported encoding

Behaviour:
- ALU codes: and=0000, sll=0001, add=0010, or=0011, sub=0100, slt=0101, xor=0110, srl=0111, sra=1000, none=1111.
- Decode is combinational on in_inst; the bundle is written to the FIFO tail on an accept (in_valid & in_ready & ~flush).
- Latency: a bundle accepted into an empty FIFO is on outputs with out_valid=1 the next cycle.
- Opcode 0x33: rs1/rs2/rd from fields; imm=0; use_imm=0; reg_write=1.
  - Operation selected by {funct7,funct3}: add, sub (f7=0x20), sll, slt, sltu, xor, srl, sra (f7=0x20, f3=5), or, and.
  - Any other funct7 gives illegal.
- Opcode 0x13: imm = sext(inst[31:20]); rs2_num=0; use_imm=1.
  - f3=0 addi, 2 slti, 3 sltiu, 4 xori, 6 ori, 7 andi.
  - f3=1 slli and f3=5 srli/srai: imm = zero-extended inst[24:20]; inst[31:25] must be 0x00 (0x20 allowed for srai), else illegal.
- Opcode 0x03: load; f3 in {0,1,2,4,5} else illegal; alu=add; imm=sext(I); mem_read=1; reg_write=1.
- Opcode 0x23: store; f3 in {0,1,2} else illegal; imm = sext({inst[31:25], inst[11:7]}); alu=add; mem_write=1; rd_num=0; reg_write=0.
- Opcode 0x37: LUI; imm = sext({inst[31:12], 12'b0}); rs1_num=0; alu=add; use_imm=1; reg_write=1.
- is_unsigned=1 only for sltu/sltiu and for loads with f3=4/5; 0 otherwise. It is never sticky.
- Illegal bundles: all register numbers, imm, mem_*, reg_write and use_imm are 0; alu_control=1111; illegal=1.
  - If ILLEGAL_TRAP=0, the bundle is not written to the FIFO, although in_ready still completes the handshake.
- FIFO: read and write pointers plus count.
  - in_ready = (count < DEPTH) | out_ready. A full FIFO accepts only when the head pops in the same cycle.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
  - Output fields are driven from the head entry and stay stable while out_valid & ~out_ready.
- flush: count, pointers and out_valid cleared next cycle; any in_valid that cycle is dropped. flush has priority over push and pop.
- rst (synchronous, priority over flush): count=0, pointers=0, out_valid=0. All bundle outputs read 0 except alu_control=1111. in_ready=1 from the first cycle after reset.
- Reset mid-stream: buffered entries are lost; no partial bundle is emitted.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) at pc=0x100 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu=0010, reg_write=1, out_pc=0x100.
- addi x5,x0,-1 (0xFFF00293) -> imm=0xFFFFFFFF, use_imm=1, alu=0010. sltiu x6,x5,1 (0x0012B313) -> alu=0101, is_unsigned=1. The next add shows is_unsigned=0.
- sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, mem_write=1, reg_write=0. lui x7,0x12345 (0x123453B7) -> imm=0x12345000, rs1=0.
- Hold out_ready=0 and stream 3 instructions -> in_ready drops after 2 accepted and head outputs stay stable. Release -> bundles emerge in order with no loss or duplication.
- Buffer holds 2 entries and flush=1 with in_valid=1 -> next cycle out_valid=0, count=0; the flushed input never appears.
- Opcode 0x7F with ILLEGAL_TRAP=1 -> illegal=1, alu=1111. With ILLEGAL_TRAP=0 -> no out_valid, in_ready stays 1. slli with inst[25]=1 -> illegal=1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage -- pipelined RV32 instruction decoder with a small output FIFO.
//
// Decodes R-type, I-type ALU, load, store and LUI instructions arriving from
// fetch. Each decoded bundle is pushed into a DEPTH-entry FIFO. The FIFO
// absorbs one cycle of downstream stall without dropping input throughput.
//
// Parameters:
//   XLEN         width of the PC and immediate outputs (32 or 64)
//   DEPTH        output FIFO entries (power of two, >= 2)
//   ILLEGAL_TRAP 1: illegal encodings are emitted with illegal=1
//                0: illegal encodings are accepted but never emitted
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           discard buffered and incoming instructions this cycle
//   in_valid/ready  fetch handshake; in_inst, in_pc carry the instruction
//   out_valid/ready execute handshake on the FIFO head
//   out_pc .. illegal  decoded fields of the head bundle
//                      (idle value: all 0, alu_control = 4'b1111)
module decode_stage #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 2,
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      rs1_num,
   output logic [4:0]      rs2_num,
   output logic [4:0]      rd_num,
   output logic [XLEN-1:0] imm,
   output logic [3:0]      alu_control,
   output logic            is_unsigned,
   output logic            use_imm,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic            illegal
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   localparam logic [6:0] OP_R     = 7'h33;
   localparam logic [6:0] OP_IMM   = 7'h13;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_STORE = 7'h23;
   localparam logic [6:0] OP_LUI   = 7'h37;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_SUB  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_XOR  = 4'b0110,
      ALU_SRL  = 4'b0111,
      ALU_SRA  = 4'b1000,
      ALU_NONE = 4'b1111
   } alu_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      alu_e            alu;
      logic            is_unsigned;
      logic            use_imm;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            illegal;
   } bundle_t;

   // ---------------------------------------------------------------------
   // Instruction fields and immediates
   // ---------------------------------------------------------------------
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] f_rs1, f_rs2, f_rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_sh;

   assign opcode = in_inst[6:0];
   assign f_rd   = in_inst[11:7];
   assign funct3 = in_inst[14:12];
   assign f_rs1  = in_inst[19:15];
   assign f_rs2  = in_inst[24:20];
   assign funct7 = in_inst[31:25];

   // Size casts of signed operands sign-extend to XLEN.
   assign imm_i  = XLEN'($signed(in_inst[31:20]));
   assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
   assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
   assign imm_sh = XLEN'(in_inst[24:20]);

   // ---------------------------------------------------------------------
   // Combinational decode
   // ---------------------------------------------------------------------
   bundle_t dec;
   logic    bad;

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      dec     = '0;
      dec.alu = ALU_NONE;
      bad     = 1'b0;

      case (opcode)
         OP_R: begin
            dec.rs1       = f_rs1;
            dec.rs2       = f_rs2;
            dec.rd        = f_rd;
            dec.reg_write = (f_rd != 5'd0);
            if (funct7 == 7'h00) begin
               case (funct3)
                  3'd0: dec.alu = ALU_ADD;
                  3'd1: dec.alu = ALU_SLL;
                  3'd2: dec.alu = ALU_SLT;
                  3'd3: begin
                     dec.alu         = ALU_SLT;
                     dec.is_unsigned = 1'b1;
                  end
                  3'd4: dec.alu = ALU_XOR;
                  3'd5: dec.alu = ALU_SRL;
                  3'd6: dec.alu = ALU_OR;
                  3'd7: dec.alu = ALU_AND;
               endcase
            end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
               dec.alu = ALU_SUB;
            end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
               dec.alu = ALU_SRA;
            end else begin
               bad = 1'b1;
            end
         end

         OP_IMM: begin
            dec.rs1       = f_rs1;
            dec.rd        = f_rd;
            dec.imm       = imm_i;
            dec.use_imm   = 1'b1;
            dec.reg_write = (f_rd != 5'd0);
            case (funct3)
               3'd0: dec.alu = ALU_ADD;
               3'd2: dec.alu = ALU_SLT;
               3'd3: begin
                  dec.alu         = ALU_SLT;
                  dec.is_unsigned = 1'b1;
               end
               3'd4: dec.alu = ALU_XOR;
               3'd6: dec.alu = ALU_OR;
               3'd7: dec.alu = ALU_AND;
               3'd1: begin
                  // Shift amount is a zero-extended 5-bit field; the upper
                  // bits are an opcode extension, not part of the immediate.
                  dec.imm = imm_sh;
                  if (funct7 == 7'h00) dec.alu = ALU_SLL;
                  else                 bad     = 1'b1;
               end
               3'd5: begin
                  dec.imm = imm_sh;
                  if (funct7 == 7'h00)      dec.alu = ALU_SRL;
                  else if (funct7 == 7'h20) dec.alu = ALU_SRA;
                  else                      bad     = 1'b1;
               end
            endcase
         end

         OP_LOAD: begin
            dec.rs1       = f_rs1;
            dec.rd        = f_rd;
            dec.imm       = imm_i;
            dec.alu       = ALU_ADD;
            dec.use_imm   = 1'b1;
            dec.mem_read  = 1'b1;
            dec.reg_write = (f_rd != 5'd0);
            case (funct3)
               3'd0, 3'd1, 3'd2: ;
               3'd4, 3'd5: dec.is_unsigned = 1'b1;
               default:    bad = 1'b1;
            endcase
         end

         OP_STORE: begin
            dec.rs1       = f_rs1;
            dec.rs2       = f_rs2;
            dec.imm       = imm_s;
            dec.alu       = ALU_ADD;
            dec.use_imm   = 1'b1;
            dec.mem_write = 1'b1;
            if (funct3 > 3'd2) bad = 1'b1;
         end

         OP_LUI: begin
            dec.rd        = f_rd;
            dec.imm       = imm_u;
            dec.alu       = ALU_ADD;
            dec.use_imm   = 1'b1;
            dec.reg_write = (f_rd != 5'd0);
         end

         default: bad = 1'b1;
      endcase

      // Illegal bundles carry no register, memory or immediate side effects.
      if (bad) begin
         dec         = '0;
         dec.alu     = ALU_NONE;
         dec.illegal = 1'b1;
      end
      dec.pc = in_pc;
   end

   // ---------------------------------------------------------------------
   // Output FIFO
   // ---------------------------------------------------------------------
   bundle_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             accept, push, pop;

   assign out_valid = (count != '0);
   // A full FIFO still accepts when its head leaves in the same cycle.
   assign in_ready  = (count < DEPTH_CNT) | out_ready;
   // Illegal words complete the handshake even when they are not stored.
   assign accept    = in_valid & in_ready & ~flush;
   assign push      = accept & (ILLEGAL_TRAP | ~dec.illegal);
   assign pop       = out_valid & out_ready;

   // NOTE: the storage array has no reset; the count and pointers define
   // which entries are meaningful, so clearing the data would be wasted logic.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= dec;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      if (rst || flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap.
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Head bundle; an empty FIFO presents the idle bundle.
   bundle_t head;

   always_comb begin
      head     = '0;
      head.alu = ALU_NONE;
      if (out_valid) head = mem[rd_ptr];
   end

   assign out_pc      = head.pc;
   assign rs1_num     = head.rs1;
   assign rs2_num     = head.rs2;
   assign rd_num      = head.rd;
   assign imm         = head.imm;
   assign alu_control = head.alu;
   assign is_unsigned = head.is_unsigned;
   assign use_imm     = head.use_imm;
   assign reg_write   = head.reg_write;
   assign mem_read    = head.mem_read;
   assign mem_write   = head.mem_write;
   assign illegal     = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: one instance traps illegal encodings, one drops
// them. Both see identical stimulus and are compared each cycle against a
// queue-based reference model that decodes from the instruction-set rules.
module tb_decode_stage;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        uns;
      logic        use_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        illegal;
   } exp_t;

   // ALU code for each funct3 when funct7 is zero (shared by R and I forms).
   localparam logic [3:0] F3_ALU [8] = '{4'h2, 4'h1, 4'h5, 4'h5, 4'h6, 4'h7, 4'h3, 4'h0};

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_inst, in_pc;

   logic        a_in_ready, a_out_valid, a_uns, a_use_imm, a_rw, a_mr, a_mw, a_ill;
   logic [31:0] a_out_pc, a_imm;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [3:0]  a_alu;
   logic        b_in_ready, b_out_valid, b_uns, b_use_imm, b_rw, b_mr, b_mw, b_ill;
   logic [31:0] b_out_pc, b_imm;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [3:0]  b_alu;

   exp_t a_obs, b_obs;
   assign a_obs = {a_out_pc, a_rs1, a_rs2, a_rd, a_imm, a_alu, a_uns, a_use_imm, a_rw, a_mr, a_mw, a_ill};
   assign b_obs = {b_out_pc, b_rs1, b_rs2, b_rd, b_imm, b_alu, b_uns, b_use_imm, b_rw, b_mr, b_mw, b_ill};

   int   checks   = 0;
   int   failures = 0;
   exp_t qa [$];
   exp_t qb [$];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .DEPTH(DEPTH), .ILLEGAL_TRAP(1'b1)) u_dut_trap (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
      .rs1_num(a_rs1), .rs2_num(a_rs2), .rd_num(a_rd), .imm(a_imm),
      .alu_control(a_alu), .is_unsigned(a_uns), .use_imm(a_use_imm),
      .reg_write(a_rw), .mem_read(a_mr), .mem_write(a_mw), .illegal(a_ill)
   );

   decode_stage #(.XLEN(32), .DEPTH(DEPTH), .ILLEGAL_TRAP(1'b0)) u_dut_drop (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
      .rs1_num(b_rs1), .rs2_num(b_rs2), .rd_num(b_rd), .imm(b_imm),
      .alu_control(b_alu), .is_unsigned(b_uns), .use_imm(b_use_imm),
      .reg_write(b_rw), .mem_read(b_mr), .mem_write(b_mw), .illegal(b_ill)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t idle_bundle();
      exp_t e = '0;
      e.alu = 4'hF;
      return e;
   endfunction

   // Reference decode written from the instruction-set rules.
   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
      exp_t        e     = '0;
      logic        ok    = 1'b0;
      logic [2:0]  f3    = i[14:12];
      logic [6:0]  f7    = i[31:25];
      logic [31:0] imm_i = $signed(i) >>> 20;
      case (i[6:0])
         7'h33: begin
            ok          = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.rs1       = i[19:15];
            e.rs2       = i[24:20];
            e.rd        = i[11:7];
            e.reg_write = (i[11:7] != 0);
            e.alu       = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'h4 : 4'h8) : F3_ALU[f3];
            e.uns       = (f3 == 3'd3);
         end
         7'h13: begin
            e.rs1       = i[19:15];
            e.rd        = i[11:7];
            e.use_imm   = 1'b1;
            e.reg_write = (i[11:7] != 0);
            e.uns       = (f3 == 3'd3);
            if (f3 == 3'd1 || f3 == 3'd5) begin
               ok    = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
               e.imm = {27'd0, i[24:20]};
               e.alu = (f7 == 7'h20) ? 4'h8 : F3_ALU[f3];
            end else begin
               ok    = 1'b1;
               e.imm = imm_i;
               e.alu = F3_ALU[f3];
            end
         end
         7'h03: begin
            ok          = (f3 != 3'd3) && (f3 <= 3'd5);
            e.rs1       = i[19:15];
            e.rd        = i[11:7];
            e.imm       = imm_i;
            e.alu       = 4'h2;
            e.use_imm   = 1'b1;
            e.mem_read  = 1'b1;
            e.reg_write = (i[11:7] != 0);
            e.uns       = (f3 >= 3'd4);
         end
         7'h23: begin
            ok          = (f3 <= 3'd2);
            e.rs1       = i[19:15];
            e.rs2       = i[24:20];
            e.imm       = {imm_i[31:5], i[11:7]};
            e.alu       = 4'h2;
            e.use_imm   = 1'b1;
            e.mem_write = 1'b1;
         end
         7'h37: begin
            ok          = 1'b1;
            e.rd        = i[11:7];
            e.imm       = i & 32'hFFFF_F000;
            e.alu       = 4'h2;
            e.use_imm   = 1'b1;
            e.reg_write = (i[11:7] != 0);
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e         = idle_bundle();
         e.illegal = 1'b1;
      end
      e.pc = pc;
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] i = $urandom;
      int          k = $urandom_range(0, 9);
      int          s = $urandom_range(0, 4);
      case (k)
         0, 1, 2: begin
            i[6:0] = 7'h33;
            if (s < 2)      i[31:25] = 7'h00;
            else if (s < 4) i[31:25] = 7'h20;
         end
         3, 4: begin
            i[6:0] = 7'h13;
            if (s < 2)       i[31:25] = 7'h00;
            else if (s == 2) i[31:25] = 7'h20;
         end
         5: i[6:0] = 7'h03;
         6: i[6:0] = 7'h23;
         7: i[6:0] = 7'h37;
         9: begin
            i[6:0]   = 7'h33;
            i[31:25] = 7'h00;
            i[11:7]  = 5'd0;
         end
         default: ;
      endcase
      return i;
   endfunction

   // Drive one cycle at the falling edge, compare both DUTs against the
   // model state, then advance the model through the next rising edge.
   task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rs);
      exp_t d;
      logic rdy_a, rdy_b;
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      #1;
      rdy_a = (qa.size() < DEPTH) || ordy;
      rdy_b = (qb.size() < DEPTH) || ordy;
      check("valid_trap", a_out_valid, qa.size() != 0);
      check("ready_trap", a_in_ready, rdy_a);
      if (qa.size() != 0) check("head_trap", a_obs, qa[0]);
      else                check("idle_trap", a_obs, idle_bundle());
      check("valid_drop", b_out_valid, qb.size() != 0);
      check("ready_drop", b_in_ready, rdy_b);
      if (qb.size() != 0) check("head_drop", b_obs, qb[0]);
      else                check("idle_drop", b_obs, idle_bundle());
      d = ref_decode(inst, pc);
      if (rs || fl) begin
         qa.delete();
         qb.delete();
      end else begin
         if (qa.size() != 0 && ordy) void'(qa.pop_front());
         if (v && rdy_a) qa.push_back(d);
         if (qb.size() != 0 && ordy) void'(qb.pop_front());
         if (v && rdy_b && !d.illegal) qb.push_back(d);
      end
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_inst   = 32'd0;
      in_pc     = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", a_out_valid, 1'b0);
      check("rst_alu", a_alu, 4'hF);
      check("rst_in_ready", a_in_ready, 1'b1);
      check("rst_imm", a_imm, 32'd0);
      check("rst_drop_valid", b_out_valid, 1'b0);
      @(negedge clk);

      // Basic decodes, one per cycle with the consumer always ready.
      step(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0, 1'b0);
      check("add_valid", a_out_valid, 1'b1);
      check("add_rs1", a_rs1, 5'd1);
      check("add_rs2", a_rs2, 5'd2);
      check("add_rd", a_rd, 5'd3);
      check("add_alu", a_alu, 4'b0010);
      check("add_reg_write", a_rw, 1'b1);
      check("add_pc", a_out_pc, 32'h100);
      step(1'b1, 32'hFFF00293, 32'h104, 1'b1, 1'b0, 1'b0);
      check("addi_imm", a_imm, 32'hFFFF_FFFF);
      check("addi_use_imm", a_use_imm, 1'b1);
      check("addi_alu", a_alu, 4'b0010);
      step(1'b1, 32'h0012B313, 32'h108, 1'b1, 1'b0, 1'b0);
      check("sltiu_alu", a_alu, 4'b0101);
      check("sltiu_unsigned", a_uns, 1'b1);
      step(1'b1, 32'h002081B3, 32'h10C, 1'b1, 1'b0, 1'b0);
      check("add_not_unsigned", a_uns, 1'b0);
      step(1'b1, 32'hFE20AE23, 32'h110, 1'b1, 1'b0, 1'b0);
      check("sw_imm", a_imm, 32'hFFFF_FFFC);
      check("sw_mem_write", a_mw, 1'b1);
      check("sw_reg_write", a_rw, 1'b0);
      step(1'b1, 32'h123453B7, 32'h114, 1'b1, 1'b0, 1'b0);
      check("lui_imm", a_imm, 32'h1234_5000);
      check("lui_rs1", a_rs1, 5'd0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Downstream stall: two accepted, third refused, head held stable.
      step(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hFFF00293, 32'h204, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0012B313, 32'h208, 1'b0, 1'b0, 1'b0);
      check("stall_in_ready", a_in_ready, 1'b0);
      check("stall_head_pc", a_out_pc, 32'h200);
      step(1'b1, 32'h0012B313, 32'h208, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Flush with a full buffer and a new instruction offered.
      step(1'b1, 32'h002081B3, 32'h300, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h123453B7, 32'h304, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hFE20AE23, 32'h308, 1'b0, 1'b1, 1'b0);
      check("flush_out_valid", a_out_valid, 1'b0);
      check("flush_in_ready", a_in_ready, 1'b1);
      repeat (2) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Illegal encodings: emitted by the trapping instance, dropped by the other.
      step(1'b1, 32'h0000007F, 32'h400, 1'b1, 1'b0, 1'b0);
      check("ill_flag", a_ill, 1'b1);
      check("ill_alu", a_alu, 4'b1111);
      check("ill_drop_valid", b_out_valid, 1'b0);
      check("ill_drop_ready", b_in_ready, 1'b1);
      step(1'b1, 32'h02109093, 32'h404, 1'b1, 1'b0, 1'b0);
      check("slli_bad_f7", a_ill, 1'b1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Reset while the buffer holds data.
      step(1'b1, 32'h002081B3, 32'h500, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hFFF00293, 32'h504, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h123453B7, 32'h508, 1'b0, 1'b0, 1'b1);
      check("midrst_valid", a_out_valid, 1'b0);
      check("midrst_drop_valid", b_out_valid, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Randomized traffic with stalls, flushes and occasional reset.
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 99) == 0);
      end
      repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
